// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO read-side stream adapter (fifo_rd_stream, fifo_rd_skid_buf).
package fifo_stream_pkg;

    localparam int unsigned C_BUF_DEPTH = 2;

    typedef logic [1:0] occ_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry head/tail buffer absorbing the FIFO's registered read latency.
module fifo_rd_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int unsigned G_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [G_WIDTH-1:0] i_data,
    input  logic               i_pop,
    output occ_t               o_occ,
    output logic [G_WIDTH-1:0] o_head
);

    buf_state_e         r_state;
    buf_state_e         w_state_nxt;
    logic [G_WIDTH-1:0] r_head;
    logic [G_WIDTH-1:0] r_tail;
    logic [G_WIDTH-1:0] w_head_nxt;
    logic [G_WIDTH-1:0] w_tail_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= BUF_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // A push arriving while full only happens on a protocol error and is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            BUF_EMPTY: begin
                if (i_push) begin
                    w_state_nxt = BUF_ONE;
                    w_head_nxt  = i_data;
                end
            end
            BUF_ONE: begin
                if (i_push && i_pop) begin
                    w_head_nxt = i_data;
                end else if (i_push) begin
                    w_state_nxt = BUF_TWO;
                    w_tail_nxt  = i_data;
                end else if (i_pop) begin
                    w_state_nxt = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (i_pop) begin
                    w_state_nxt = BUF_ONE;
                    w_head_nxt  = r_tail;
                end
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    assign o_occ  = occ_t'(r_state);
    assign o_head = r_head;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous_fifo read port into a valid/ready stream.
// Optional packet framing on o_last is enabled by defining FIFO_RD_STREAM_LAST_EN.
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int unsigned G_WIDTH   = 8,
    parameter int unsigned G_PKT_LEN = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic               o_fifo_rd,
    input  logic [G_WIDTH-1:0] i_fifo_data,
    input  logic               i_fifo_empty,
    input  logic               i_fifo_rd_done,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [G_WIDTH-1:0] o_data,
    output logic               o_last,
    output logic               o_err
);

    if (G_PKT_LEN < 1) begin : g_bad_pkt_len
        $error("fifo_rd_stream: G_PKT_LEN must be >= 1");
    end

    occ_t               w_occ;
    logic [G_WIDTH-1:0] w_head;
    logic               w_pop;
    logic               w_rd;
    logic [2:0]         w_level;
    logic               r_inflight;
    logic               r_err;

    fifo_rd_skid_buf #(
        .G_WIDTH (G_WIDTH)
    ) u_buf (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (i_fifo_rd_done),
        .i_data (i_fifo_data),
        .i_pop  (w_pop),
        .o_occ  (w_occ),
        .o_head (w_head)
    );

    assign o_valid = (w_occ != occ_t'(0));
    assign w_pop   = o_valid && i_ready;

    // Counting the in-flight read as occupied keeps occ + inflight <= 2.
    assign w_level   = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_rd      = !i_rst && !i_fifo_empty && (w_level < 3'(C_BUF_DEPTH));
    assign o_fifo_rd = w_rd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            if (i_fifo_rd_done && !r_inflight) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_data = w_head;
    assign o_err  = r_err;

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int unsigned C_CNT_W = $clog2(G_PKT_LEN + 1);

    logic [C_CNT_W-1:0] r_beat_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= (r_beat_cnt == C_CNT_W'(G_PKT_LEN - 1)) ? '0 : r_beat_cnt + C_CNT_W'(1);
        end
    end

    assign o_last = o_valid && (r_beat_cnt == C_CNT_W'(G_PKT_LEN - 1));
`else
    assign o_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based FIFO and stream models plus directed literals.
`timescale 1ns/1ps
module tb_fifo_rd_stream;

    localparam int unsigned W   = 8;
    localparam int unsigned PKT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_rd;
    logic [W-1:0] fifo_data;
    logic         fifo_empty;
    logic         fifo_done;
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;
    logic         err;

    always #5 clk = ~clk;

    fifo_rd_stream #(.G_WIDTH(W), .G_PKT_LEN(PKT)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_fifo_rd      (fifo_rd),
        .i_fifo_data    (fifo_data),
        .i_fifo_empty   (fifo_empty),
        .i_fifo_rd_done (fifo_done),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_data         (data),
        .o_last         (last),
        .o_err          (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // FIFO model (registered read: data and done appear the cycle after a read)
    logic [W-1:0] fifo_q[$];
    bit           f_done = 1'b0;
    logic [W-1:0] f_data = '0;

    // Stream model: buffered words, outstanding read, sticky error, accepted beats
    logic [W-1:0] buf_q[$];
    bit           m_inflight = 1'b0;
    bit           m_err      = 1'b0;
    int           m_beats    = 0;

    logic [W-1:0] sb_q[$];
    bit           sb_en = 1'b1;

    bit           c_valid, c_rd, c_last, c_err, c_pop, c_empty;
    logic [W-1:0] c_data;
    bit           p_stall = 1'b0;
    logic [W-1:0] p_data;
    bit           p_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle(input bit rst_i, input bit rdy, input bit wr, input logic [W-1:0] wd,
                         input bit force_done);
        bit exp_valid, exp_rd, exp_last, pop;
        int occ;
        @(negedge clk);
        rst        = rst_i;
        ready      = rdy;
        fifo_empty = (fifo_q.size() == 0);
        fifo_done  = f_done | force_done;
        fifo_data  = force_done ? 8'hEE : f_data;
        #1;
        occ       = buf_q.size();
        exp_valid = (occ != 0);
        pop       = exp_valid && rdy;
        exp_rd    = !rst_i && !fifo_empty && ((occ + int'(m_inflight) - int'(pop)) < 2);
`ifdef FIFO_RD_STREAM_LAST_EN
        exp_last  = exp_valid && ((m_beats % PKT) == PKT - 1);
`else
        exp_last  = 1'b0;
`endif
        check("o_valid", 32'(valid), 32'(exp_valid));
        if (exp_valid) check("o_data", 32'(data), 32'(buf_q[0]));
        check("o_fifo_rd", 32'(fifo_rd), 32'(exp_rd));
        check("o_last", 32'(last), 32'(exp_last));
        check("o_err", 32'(err), 32'(m_err));
        if (p_stall && !rst_i) begin
            check("hold_data", 32'(data), 32'(p_data));
            check("hold_last", 32'(last), 32'(p_last));
        end
        if (pop && sb_en) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL order: got %0h expected nothing (cycle %0d)", data, cyc);
            end else begin
                check("order", 32'(data), 32'(sb_q.pop_front()));
            end
        end
        c_valid = valid;
        c_data  = data;
        c_rd    = fifo_rd;
        c_last  = last;
        c_err   = err;
        c_pop   = valid && rdy;
        c_empty = fifo_empty;
        p_stall = valid && !rdy;
        p_data  = data;
        p_last  = last;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_i) begin
            fifo_q.delete();
            f_done = 1'b0;
        end else begin
            f_done = 1'b0;
            if (fifo_rd) begin
                check("no_underflow", 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) begin
                    f_data = fifo_q.pop_front();
                    f_done = 1'b1;
                end
            end
            if (wr) begin
                fifo_q.push_back(wd);
                if (sb_en) sb_q.push_back(wd);
            end
        end
        if (rst_i) begin
            buf_q.delete();
            sb_q.delete();
            m_inflight = 1'b0;
            m_err      = 1'b0;
            m_beats    = 0;
            p_stall    = 1'b0;
        end else begin
            if (fifo_done && !m_inflight) m_err = 1'b1;
            if (pop) begin
                void'(buf_q.pop_front());
                m_beats++;
            end
            if (fifo_done && occ < 2) buf_q.push_back(fifo_data);
            m_inflight = exp_rd;
        end
    endtask

    logic [W-1:0] beats[16];
    bit           lasts[16];
    int           nb, b0, bl, k_empty, k_valid, acc, written;

    initial begin
        rst        = 1'b1;
        ready      = 1'b0;
        fifo_empty = 1'b1;
        fifo_done  = 1'b0;
        fifo_data  = '0;

        cycle(1, 0, 0, 8'h00, 0);
        cycle(1, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);
        check("rst_valid", 32'(c_valid), 32'd0);
        check("rst_data", 32'(c_data), 32'd0);
        check("rst_last", 32'(c_last), 32'd0);
        check("rst_err", 32'(c_err), 32'd0);
        check("rst_rd", 32'(c_rd), 32'd0);

        // 1: eight words with the sink always ready
        k_empty = -1; k_valid = -1; nb = 0; b0 = 0; bl = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, i < 8, 8'(i + 1), 0);
            if (k_empty < 0 && !c_empty) k_empty = i;
            if (k_valid < 0 && c_valid) k_valid = i;
            if (c_pop && nb < 16) begin
                beats[nb] = c_data;
                if (nb == 0) b0 = i;
                bl = i;
                nb++;
            end
        end
        check("t1_latency", 32'(k_valid - k_empty), 32'd2);
        check("t1_nbeats", 32'(nb), 32'd8);
        for (int j = 0; j < 8; j++) check("t1_beat", 32'(beats[j]), 32'(j + 1));
        check("t1_contig", 32'(bl - b0), 32'd7);
        check("t1_idle_valid", 32'(c_valid), 32'd0);
        check("t1_err", 32'(c_err), 32'd0);

        // 2: preload with the sink stalled, then release
        for (int i = 0; i < 10; i++) cycle(0, 0, i < 4, 8'(8'h11 + i), 0);
        check("t2_rd_stopped", 32'(c_rd), 32'd0);
        check("t2_valid", 32'(c_valid), 32'd1);
        check("t2_head", 32'(c_data), 32'h11);
        check("t2_fifo_left", 32'(fifo_q.size()), 32'd2);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 0, 8'h00, 0);
            if (c_pop && nb < 16) begin
                beats[nb] = c_data;
                if (nb == 0) b0 = i;
                bl = i;
                nb++;
            end
        end
        check("t2_nbeats", 32'(nb), 32'd4);
        for (int j = 0; j < 4; j++) check("t2_beat", 32'(beats[j]), 32'(8'h11 + j));
        check("t2_contig", 32'(bl - b0), 32'd3);

        // 3: random traffic, 1000 words
        acc = 0; written = 0;
        for (int i = 0; i < 20000 && acc < 1000; i++) begin
            bit wr;
            wr = (written < 1000) && ($urandom_range(0, 99) < 60);
            cycle(0, 1'($urandom_range(0, 1)), wr, 8'($urandom), 0);
            if (wr) written++;
            if (c_pop) acc++;
        end
        check("t3_accepted", 32'(acc), 32'd1000);
        check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // 4: reset while a read is outstanding
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, i < 3, 8'(8'h31 + i), 0);
            if (m_inflight && buf_q.size() >= 1) break;
        end
        check("t4_setup_inflight", 32'(m_inflight), 32'd1);
        cycle(1, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);
        check("t4_valid", 32'(c_valid), 32'd0);
        check("t4_err", 32'(c_err), 32'd0);
        check("t4_data", 32'(c_data), 32'd0);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, i == 0, 8'hA5, 0);
            if (c_pop && nb < 16) begin
                beats[nb] = c_data;
                nb++;
            end
        end
        check("t4_nbeats", 32'(nb), 32'd1);
        check("t4_first", 32'(beats[0]), 32'hA5);

        // 5: spurious read-done raises a sticky error
        sb_en = 1'b0;
        cycle(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 8'h00, 0);
            check("t5_err_sticky", 32'(c_err), 32'd1);
        end
        cycle(1, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);
        check("t5_err_cleared", 32'(c_err), 32'd0);
        sb_en = 1'b1;

        // 6: packet framing over 12 words with random stalls
        nb = 0;
        for (int i = 0; i < 400 && nb < 12; i++) begin
            cycle(0, 1'($urandom_range(0, 1)), i < 12, 8'(8'h41 + i), 0);
            if (c_pop && nb < 16) begin
                lasts[nb] = c_last;
                nb++;
            end
        end
        check("t6_nbeats", 32'(nb), 32'd12);
        for (int j = 0; j < 12; j++) begin
`ifdef FIFO_RD_STREAM_LAST_EN
            check("t6_last", 32'(lasts[j]), 32'((j % PKT) == PKT - 1));
`else
            check("t6_last", 32'(lasts[j]), 32'd0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
